i2c_target: RTL and testbench
=============================

Name: i2c_target

Overview:
- I2C target (responder) matching the team's I2C initiator; the bus end that answers address, write and read transfers.
- Oversamples the SCL/SDA bus lines on the system clock. Detects START, repeated START and STOP. Matches a 7-bit address.
- Stores written bytes in an internal byte register file with an auto-incrementing pointer, and returns bytes on reads.
- Drives SDA open-drain through a pull-low enable.

Parameters:
- TARGET_ADDR, 7'h50, 7-bit bus address this target answers to.
- DEPTH, 16, number of bytes in the register file (power of 2).
- PW, $clog2(DEPTH), pointer width.

Ports:
- CLK  input  1  system clock, at least 8x SCL frequency.
- RST_N  input  1  synchronous active-low reset.
- SCL_in  input  1  raw bus SCL level.
- SDA_in  input  1  raw bus SDA level.
- SDA_oe  output  1  1 = pull SDA low; 0 = release (bus pull-up).
- wr_en  output  1  one-CLK pulse when a data byte is committed to the register file.
- wr_addr  output  PW  register index of the committed byte.
- wr_data  output  8  committed byte.
- rd_en  output  1  one-CLK pulse when a byte is loaded for transmit.
- rd_addr  output  PW  register index of the loaded byte.
- busy  output  1  high from an addressed START until STOP or NACK release.

Behaviour:
- Reset (RST_N low at a CLK rising edge):
  - All outputs become 0 and the state becomes IDLE.
  - Pointer and all register bytes become 0.
  - Both synchronizer stages are set to 1.
- Input conditioning:
  - 2-flop synchronizer on SCL_in and SDA_in, then a previous-value register for edge detect.
  - Event-to-action latency: SDA_oe changes at most 3 CLK after the raw SCL falling edge.
- Bus events (synchronized levels):
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - SDA rise/fall is a START/STOP only when SCL is high; with SCL low it is data.
  - Bits are sampled on SCL rise. SDA_oe may change only on SCL fall.
  - All bytes are MSB first.
- START from any state, including mid-byte (repeated START): go to ADDR, clear the bit counter, release SDA_oe.
- STOP from any state: go to IDLE, release SDA_oe, busy=0. A partial byte is discarded and never written.
- State machine:
  - IDLE: wait for START.
  - ADDR: shift 8 bits {addr[6:0], RW} (RW=1 means read).
    - Match: on the next SCL fall assert SDA_oe, go to ADDR_ACK, busy=1.
    - Mismatch: go to WAIT_STOP with no ACK.
  - ADDR_ACK: hold SDA_oe through the 9th SCL high. On the following SCL fall:
    - RW=0: release SDA_oe, go to WR_DATA; the first byte of the transfer is the pointer byte.
    - RW=1: load byte[ptr], pulse rd_en, drive bit7 (SDA_oe = ~bit), go to RD_DATA.
  - WR_DATA: shift 8 bits. On the 8th SCL rise, with fb = first byte of the transfer:
    - fb: ptr <= byte[PW-1:0]; upper bits are ignored.
    - Otherwise: mem[ptr] <= byte, wr_en pulse with wr_addr=ptr, then ptr <= ptr+1 mod DEPTH.
    - Then ACK exactly as in ADDR_ACK and return to WR_DATA. The target ACKs every write byte.
  - RD_DATA:
    - Drive bits 6..0 on successive SCL falls.
    - After the 8th bit's SCL fall, release SDA, ptr <= ptr+1 mod DEPTH, go to RD_ACK.
  - RD_ACK: sample SDA on the 9th SCL rise.
    - 0 (ACK): on the next SCL fall load the next byte, pulse rd_en, drive bit7, go to RD_DATA.
    - 1 (NACK): go to WAIT_STOP with SDA released.
  - WAIT_STOP: SDA_oe=0; only START or STOP leave this state. busy=0.
- Pointer wrap: DEPTH-1 increments to 0.
- A repeated START after a write keeps ptr, which is how a register is selected before a read.
- SDA_oe is never asserted while SCL is high, except when held through an ACK bit or a data bit.

Test Plan:
- Write: START, 0xA0 (addr 0x50 W), ptr 0x03, 0xA5, 0x3C, STOP.
  - Target ACKs all 4 bytes.
  - wr_en pulses twice: (3, 0xA5), then (4, 0x3C).
  - busy falls after STOP.
- Read: START, 0xA0, ptr 0x03, Sr, 0xA1; master ACKs byte 1 and NACKs byte 2.
  - SDA carries 0xA5 then 0x3C MSB first.
  - rd_en pulses at addresses 3 and 4.
  - SDA_oe=0 after the NACK; state WAIT_STOP until STOP.
- Address mismatch: START, 0xA2 (addr 0x51), 0xFF, STOP.
  - SDA_oe stays 0 throughout; no wr_en pulse; busy stays 0.
- Pointer wrap: write ptr 0x0F, then 0x11, 0x22.
  - wr_en at (15, 0x11) then (0, 0x22).
  - A subsequent read from ptr 0x0F returns 0x11, 0x22.
- STOP mid-byte: STOP after 4 data bits of the second data byte.
  - No wr_en pulse for that byte; state IDLE; SDA_oe=0.
- Reset mid-read: RST_N low for 1 CLK while SDA_oe=1.
  - SDA_oe=0 and busy=0 after that edge.
  - A subsequent read of ptr 0 returns 0x00.

Source files
------------

// File: rtl/i2c_target_if.sv
// Bus-side bundle of the I2C target: raw SCL/SDA levels, the open-drain
// pull-low enable, the register-file strobes and the FSM debug state.
//
// Handshake: wr_en and rd_en are single-cycle valid strobes with no ready
// (no backpressure). wr_addr/wr_data are meaningful only while wr_en is high,
// and rd_addr only while rd_en is high.
`timescale 1ns/1ps
interface i2c_target_if #(
    parameter int PW = 4
);
    logic          SCL_in;
    logic          SDA_in;
    logic          SDA_oe;
    logic          wr_en;
    logic [PW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          rd_en;
    logic [PW-1:0] rd_addr;
    logic          busy;
    logic [2:0]    dbg_state;

    // Target side: samples the bus, drives the pull-low and the strobes.
    modport slave (
        input  SCL_in,
        input  SDA_in,
        output SDA_oe,
        output wr_en,
        output wr_addr,
        output wr_data,
        output rd_en,
        output rd_addr,
        output busy,
        output dbg_state
    );

    // Bus/environment side.
    modport master (
        output SCL_in,
        output SDA_in,
        input  SDA_oe,
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  rd_en,
        input  rd_addr,
        input  busy,
        input  dbg_state
    );
endinterface

// File: rtl/i2c_target.sv
// I2C target (responder). Oversamples SCL/SDA on CLK, detects START,
// repeated START and STOP, matches a 7-bit address, and serves a byte
// register file through an auto-incrementing pointer. The first byte of a
// write transfer selects the pointer; following bytes are stored. Reads
// return bytes from the pointer onward. SDA is driven open-drain via SDA_oe.
`timescale 1ns/1ps
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         DEPTH       = 16,
    parameter int         PW          = $clog2(DEPTH)
) (
    input  logic        CLK,
    input  logic        RST_N,
    i2c_target_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_WR_DATA   = 3'd3,
        ST_RD_DATA   = 3'd4,
        ST_RD_ACK    = 3'd5,
        ST_WAIT_STOP = 3'd6
    } state_t;

    // Synchronizers and previous-value registers (idle bus is high).
    logic          r_scl_s1, r_scl_s2, r_scl_prev;
    logic          r_sda_s1, r_sda_s2, r_sda_prev;

    // FSM and datapath state.
    state_t        r_state;
    logic [3:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic [7:0]    r_tx;
    logic          r_rw;
    logic          r_first;
    logic [PW-1:0] r_ptr;
    logic          r_sda_oe;
    logic          r_busy;
    logic          r_wr_en;
    logic [PW-1:0] r_wr_addr;
    logic [7:0]    r_wr_data;
    logic          r_rd_en;
    logic [PW-1:0] r_rd_addr;
    logic [7:0]    r_mem [DEPTH];

    // Next-state values.
    state_t        w_state_nxt;
    logic [3:0]    w_bit_cnt_nxt;
    logic [7:0]    w_shift_nxt;
    logic [7:0]    w_tx_nxt;
    logic          w_rw_nxt;
    logic          w_first_nxt;
    logic [PW-1:0] w_ptr_nxt;
    logic          w_sda_oe_nxt;
    logic          w_busy_nxt;
    logic          w_wr_en_nxt;
    logic [PW-1:0] w_wr_addr_nxt;
    logic [7:0]    w_wr_data_nxt;
    logic          w_rd_en_nxt;
    logic [PW-1:0] w_rd_addr_nxt;
    logic          w_mem_we;

    // Bus events derived from synchronized levels.
    logic          w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0]    w_byte;
    logic [7:0]    w_rd_byte;

    assign w_scl_rise = r_scl_s2 & ~r_scl_prev;
    assign w_scl_fall = ~r_scl_s2 & r_scl_prev;
    // SDA edges count as START/STOP only while SCL is high on both samples.
    assign w_start    = r_scl_s2 & r_scl_prev & r_sda_prev & ~r_sda_s2;
    assign w_stop     = r_scl_s2 & r_scl_prev & ~r_sda_prev & r_sda_s2;
    // Shift register contents with the bit being sampled now appended.
    assign w_byte     = {r_shift[6:0], r_sda_s2};
    assign w_rd_byte  = r_mem[r_ptr];

    // Two-flop synchronizers plus previous-value registers for edge detect.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_scl_s1   <= 1'b1;
            r_scl_s2   <= 1'b1;
            r_scl_prev <= 1'b1;
            r_sda_s1   <= 1'b1;
            r_sda_s2   <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_s1   <= bus.SCL_in;
            r_scl_s2   <= r_scl_s1;
            r_scl_prev <= r_scl_s2;
            r_sda_s1   <= bus.SDA_in;
            r_sda_s2   <= r_sda_s1;
            r_sda_prev <= r_sda_s2;
        end
    end

    // State and datapath registers.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_tx      <= '0;
            r_rw      <= 1'b0;
            r_first   <= 1'b0;
            r_ptr     <= '0;
            r_sda_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_tx      <= w_tx_nxt;
            r_rw      <= w_rw_nxt;
            r_first   <= w_first_nxt;
            r_ptr     <= w_ptr_nxt;
            r_sda_oe  <= w_sda_oe_nxt;
            r_busy    <= w_busy_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
            r_rd_en   <= w_rd_en_nxt;
            r_rd_addr <= w_rd_addr_nxt;
        end
    end

    // Register file: cleared on reset, written at the pointer on commit.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_mem_we) begin
            r_mem[r_ptr] <= w_byte;
        end
    end

    // Next-state and output logic; START/STOP override every state.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_tx_nxt      = r_tx;
        w_rw_nxt      = r_rw;
        w_first_nxt   = r_first;
        w_ptr_nxt     = r_ptr;
        w_sda_oe_nxt  = r_sda_oe;
        w_busy_nxt    = r_busy;
        w_wr_en_nxt   = 1'b0;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        w_rd_en_nxt   = 1'b0;
        w_rd_addr_nxt = r_rd_addr;
        w_mem_we      = 1'b0;

        if (w_start) begin
            // Repeated START keeps busy and the pointer.
            w_state_nxt   = ST_ADDR;
            w_bit_cnt_nxt = '0;
            w_sda_oe_nxt  = 1'b0;
        end else if (w_stop) begin
            // Any partial byte is simply dropped.
            w_state_nxt   = ST_IDLE;
            w_sda_oe_nxt  = 1'b0;
            w_busy_nxt    = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_sda_oe_nxt = 1'b0;
                end

                ST_ADDR: begin
                    if (w_scl_rise && r_bit_cnt != 4'd8) begin
                        w_shift_nxt   = w_byte;
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                        if (r_shift[7:1] == TARGET_ADDR) begin
                            w_sda_oe_nxt = 1'b1;
                            w_busy_nxt   = 1'b1;
                            w_rw_nxt     = r_shift[0];
                            w_first_nxt  = 1'b1;
                            w_state_nxt  = ST_ADDR_ACK;
                        end else begin
                            w_busy_nxt   = 1'b0;
                            w_state_nxt  = ST_WAIT_STOP;
                        end
                    end
                end

                // ACK slot, shared by the address byte and every write byte.
                ST_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_rw) begin
                            w_sda_oe_nxt  = 1'b0;
                            w_bit_cnt_nxt = '0;
                            w_state_nxt   = ST_WR_DATA;
                        end else begin
                            // Load the byte and present its MSB right away.
                            w_tx_nxt      = {w_rd_byte[6:0], 1'b0};
                            w_sda_oe_nxt  = ~w_rd_byte[7];
                            w_rd_en_nxt   = 1'b1;
                            w_rd_addr_nxt = r_ptr;
                            w_bit_cnt_nxt = 4'd1;
                            w_state_nxt   = ST_RD_DATA;
                        end
                    end
                end

                ST_WR_DATA: begin
                    if (w_scl_rise && r_bit_cnt != 4'd8) begin
                        w_shift_nxt   = w_byte;
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd7) begin
                            if (r_first) begin
                                // Pointer byte; bits above the pointer width are ignored.
                                w_ptr_nxt   = w_byte[PW-1:0];
                                w_first_nxt = 1'b0;
                            end else begin
                                w_mem_we      = 1'b1;
                                w_wr_en_nxt   = 1'b1;
                                w_wr_addr_nxt = r_ptr;
                                w_wr_data_nxt = w_byte;
                                w_ptr_nxt     = r_ptr + 1'b1;
                            end
                        end
                    end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                        w_sda_oe_nxt = 1'b1;
                        w_state_nxt  = ST_ADDR_ACK;
                    end
                end

                // r_bit_cnt counts bits already placed on the bus.
                ST_RD_DATA: begin
                    if (w_scl_fall) begin
                        if (r_bit_cnt != 4'd8) begin
                            w_sda_oe_nxt  = ~r_tx[7];
                            w_tx_nxt      = {r_tx[6:0], 1'b0};
                            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        end else begin
                            w_sda_oe_nxt  = 1'b0;
                            w_ptr_nxt     = r_ptr + 1'b1;
                            w_bit_cnt_nxt = '0;
                            w_state_nxt   = ST_RD_ACK;
                        end
                    end
                end

                // r_shift[0] holds the initiator's ACK bit once sampled.
                ST_RD_ACK: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = {r_shift[7:1], r_sda_s2};
                        w_bit_cnt_nxt = 4'd1;
                    end else if (w_scl_fall && r_bit_cnt == 4'd1) begin
                        if (r_shift[0]) begin
                            w_sda_oe_nxt = 1'b0;
                            w_busy_nxt   = 1'b0;
                            w_state_nxt  = ST_WAIT_STOP;
                        end else begin
                            w_tx_nxt      = {w_rd_byte[6:0], 1'b0};
                            w_sda_oe_nxt  = ~w_rd_byte[7];
                            w_rd_en_nxt   = 1'b1;
                            w_rd_addr_nxt = r_ptr;
                            w_bit_cnt_nxt = 4'd1;
                            w_state_nxt   = ST_RD_DATA;
                        end
                    end
                end

                ST_WAIT_STOP: begin
                    w_sda_oe_nxt = 1'b0;
                    w_busy_nxt   = 1'b0;
                end

                default: begin
                    w_state_nxt  = ST_IDLE;
                    w_sda_oe_nxt = 1'b0;
                    w_busy_nxt   = 1'b0;
                end
            endcase
        end
    end

    assign bus.SDA_oe    = r_sda_oe;
    assign bus.wr_en     = r_wr_en;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_data   = r_wr_data;
    assign bus.rd_en     = r_rd_en;
    assign bus.rd_addr   = r_rd_addr;
    assign bus.busy      = r_busy;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: an open-drain I2C initiator model drives the bus,
// expected register-file strobes and read bytes are queued up front and
// popped by monitors as the target produces them.
`timescale 1ns/1ps
module tb_i2c_target;

    localparam int  PW = 4;
    localparam time Q  = 50ns;   // quarter SCL period (SCL = 20 CLK)

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_STOP = 3'd6;

    // Clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Bus: SDA is wired-AND of initiator and target pull-lows.
    logic m_scl = 1'b1;
    logic m_sda_low = 1'b0;

    i2c_target_if #(.PW(PW)) bus ();
    assign bus.SCL_in = m_scl;
    assign bus.SDA_in = ~(m_sda_low | bus.SDA_oe);

    i2c_target #(.TARGET_ADDR(7'h50), .DEPTH(16)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus.slave)
    );

    // Scoreboard state
    int n_cmp = 0;
    int n_err = 0;
    logic [PW+7:0] exp_wr_q[$];
    logic [PW-1:0] exp_rd_q[$];
    logic [7:0]    exp_rx_q[$];
    logic          watch_quiet = 1'b0;
    logic          quiet_viol  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pop an expectation whenever the target strobes wr_en / rd_en.
    always @(negedge clk) begin
        if (rst_n && bus.wr_en) begin
            if (exp_wr_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL wr_unexpected: got %0h:%02h expected no write", bus.wr_addr, bus.wr_data);
            end else begin
                chk("wr_strobe", {bus.wr_addr, bus.wr_data}, exp_wr_q.pop_front());
            end
        end
        if (rst_n && bus.rd_en) begin
            if (exp_rd_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rd_unexpected: got %0h expected no read", bus.rd_addr);
            end else begin
                chk("rd_strobe", bus.rd_addr, exp_rd_q.pop_front());
            end
        end
        if (watch_quiet && (bus.SDA_oe || bus.busy)) quiet_viol = 1'b1;
    end

    // Received read bytes are checked against the queued expectation.
    task automatic check_rx(input string name, input logic [7:0] got);
        if (exp_rx_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: got %02h expected nothing queued", name, got);
        end else begin
            chk(name, got, exp_rx_q.pop_front());
        end
    endtask

    // Driver tasks (initiator model)
    task automatic bus_start();
        m_sda_low = 1'b0; #Q;
        m_scl     = 1'b1; #Q;
        m_sda_low = 1'b1; #Q;
        m_scl     = 1'b0; #Q;
    endtask

    task automatic bus_stop();
        m_sda_low = 1'b1; #Q;
        m_scl     = 1'b1; #Q;
        m_sda_low = 1'b0; #(2*Q);
    endtask

    task automatic send_bit(input logic b);
        m_sda_low = ~b; #Q;
        m_scl     = 1'b1; #(2*Q);
        m_scl     = 1'b0; #Q;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_sda_low = 1'b0; #Q;
        m_scl     = 1'b1; #Q;
        ack       = bus.SDA_in; #Q;
        m_scl     = 1'b0; #Q;
    endtask

    task automatic read_byte(input logic give_ack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) begin
            m_sda_low = 1'b0; #Q;
            m_scl     = 1'b1; #Q;
            d[i]      = bus.SDA_in; #Q;
            m_scl     = 1'b0; #Q;
        end
        send_bit(~give_ack);
    endtask

    logic       ack;
    logic [7:0] rx;

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sda_oe", bus.SDA_oe, 0);
        chk("rst_busy",   bus.busy, 0);
        chk("rst_state",  bus.dbg_state, S_IDLE);
        chk("rst_wr_en",  bus.wr_en, 0);
        chk("rst_rd_en",  bus.rd_en, 0);
        rst_n = 1'b1;
        #(2*Q);

        // Write: ptr 3, then A5, 3C
        exp_wr_q.push_back({4'd3, 8'hA5});
        exp_wr_q.push_back({4'd4, 8'h3C});
        bus_start();
        write_byte(8'hA0, ack); chk("w_addr_ack", ack, 0);
        chk("w_busy", bus.busy, 1);
        write_byte(8'h03, ack); chk("w_ptr_ack", ack, 0);
        write_byte(8'hA5, ack); chk("w_d0_ack", ack, 0);
        write_byte(8'h3C, ack); chk("w_d1_ack", ack, 0);
        bus_stop();
        chk("w_busy_after_stop", bus.busy, 0);
        chk("w_state_after_stop", bus.dbg_state, S_IDLE);

        // Read back from ptr 3: ACK then NACK
        exp_rd_q.push_back(4'd3);
        exp_rd_q.push_back(4'd4);
        exp_rx_q.push_back(8'hA5);
        exp_rx_q.push_back(8'h3C);
        bus_start();
        write_byte(8'hA0, ack); chk("r_addr_w_ack", ack, 0);
        write_byte(8'h03, ack); chk("r_ptr_ack", ack, 0);
        bus_start();
        write_byte(8'hA1, ack); chk("r_addr_r_ack", ack, 0);
        read_byte(1'b1, rx); check_rx("r_byte0", rx);
        read_byte(1'b0, rx); check_rx("r_byte1", rx);
        chk("r_oe_after_nack", bus.SDA_oe, 0);
        chk("r_state_after_nack", bus.dbg_state, S_WAIT_STOP);
        chk("r_busy_after_nack", bus.busy, 0);
        bus_stop();
        chk("r_state_after_stop", bus.dbg_state, S_IDLE);

        // Address mismatch: 0x51
        watch_quiet = 1'b1;
        bus_start();
        write_byte(8'hA2, ack); chk("mm_addr_nack", ack, 1);
        write_byte(8'hFF, ack); chk("mm_data_nack", ack, 1);
        bus_stop();
        watch_quiet = 1'b0;
        chk("mm_oe_busy_quiet", quiet_viol, 0);
        chk("mm_state", bus.dbg_state, S_IDLE);

        // Pointer wrap: 15 -> 0
        exp_wr_q.push_back({4'd15, 8'h11});
        exp_wr_q.push_back({4'd0,  8'h22});
        bus_start();
        write_byte(8'hA0, ack); chk("wr_addr_ack", ack, 0);
        write_byte(8'h0F, ack); chk("wr_ptr_ack", ack, 0);
        write_byte(8'h11, ack); chk("wr_d0_ack", ack, 0);
        write_byte(8'h22, ack); chk("wr_d1_ack", ack, 0);
        bus_stop();
        exp_rd_q.push_back(4'd15);
        exp_rd_q.push_back(4'd0);
        exp_rx_q.push_back(8'h11);
        exp_rx_q.push_back(8'h22);
        bus_start();
        write_byte(8'hA0, ack);
        write_byte(8'h0F, ack);
        bus_start();
        write_byte(8'hA1, ack); chk("wrr_addr_ack", ack, 0);
        read_byte(1'b1, rx); check_rx("wrap_byte0", rx);
        read_byte(1'b0, rx); check_rx("wrap_byte1", rx);
        bus_stop();

        // STOP after 4 bits of the second data byte
        exp_wr_q.push_back({4'd5, 8'h77});
        bus_start();
        write_byte(8'hA0, ack);
        write_byte(8'h05, ack);
        write_byte(8'h77, ack); chk("sm_d0_ack", ack, 0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        bus_stop();
        chk("sm_state", bus.dbg_state, S_IDLE);
        chk("sm_oe", bus.SDA_oe, 0);

        // Reset while the target drives bit 7 of mem[0] = 0x22 (low)
        exp_rd_q.push_back(4'd0);
        bus_start();
        write_byte(8'hA0, ack);
        write_byte(8'h00, ack);
        bus_start();
        write_byte(8'hA1, ack); chk("rr_addr_ack", ack, 0);
        chk("rr_oe_before_reset", bus.SDA_oe, 1);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        chk("rr_oe_after_reset", bus.SDA_oe, 0);
        chk("rr_busy_after_reset", bus.busy, 0);
        chk("rr_state_after_reset", bus.dbg_state, S_IDLE);
        bus_stop();
        exp_rd_q.push_back(4'd0);
        exp_rx_q.push_back(8'h00);
        bus_start();
        write_byte(8'hA1, ack); chk("rr2_addr_ack", ack, 0);
        read_byte(1'b0, rx); check_rx("rr2_byte0", rx);
        bus_stop();

        // Every queued expectation must have been consumed.
        #(4*Q);
        chk("wr_q_left", exp_wr_q.size(), 0);
        chk("rd_q_left", exp_rd_q.size(), 0);
        chk("rx_q_left", exp_rx_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
